// File: rtl/ibex_arb_pkg.sv
// ibex_arb_pkg: shared types and limits for the instr/data memory arbiter
package ibex_arb_pkg;
  typedef enum logic {ArbInstr, ArbData} arb_id_e;
  localparam int unsigned ArbMaxDepth = 8;
endpackage

// File: rtl/ibex_arb_id_fifo.sv
// ibex_arb_id_fifo: in-order FIFO of requester ids for granted-but-unanswered transactions
module ibex_arb_id_fifo
  import ibex_arb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push,
  input  logic    pop,
  input  arb_id_e din,
  output logic    full,
  output logic    empty,
  output arb_id_e head
);
  localparam int unsigned PW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);
  arb_id_e        mem [Depth];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  cnt;
  logic           push_ok, pop_ok;
  assign full    = cnt == CW'(Depth);
  assign empty   = cnt == '0;
  assign head    = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  // pointers wrap modulo Depth; the wider count separates full from empty
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr == PW'(Depth - 1) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr == PW'(Depth - 1) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter: round-robin sharing of one memory port between instr and data interfaces
module ibex_mem_arbiter
  import ibex_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   instr_req_i,
  output logic                   instr_gnt_o,
  input  logic [AddrWidth-1:0]   instr_addr_i,
  output logic                   instr_rvalid_o,
  output logic [DataWidth-1:0]   instr_rdata_o,
  output logic                   instr_err_o,
  input  logic                   data_req_i,
  output logic                   data_gnt_o,
  input  logic                   data_we_i,
  input  logic [DataWidth/8-1:0] data_be_i,
  input  logic [AddrWidth-1:0]   data_addr_i,
  input  logic [DataWidth-1:0]   data_wdata_i,
  output logic                   data_rvalid_o,
  output logic [DataWidth-1:0]   data_rdata_o,
  output logic                   data_err_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  input  logic                   mem_err_i,
  output logic                   unexp_rsp_o
);
  arb_id_e last_q, win, head;
  logic    full, empty, live, hs, rsp, unexp_q;
  assign live = ~rst_i;
  assign rsp  = live & mem_rvalid_i & ~empty;
  assign hs   = mem_req_o & mem_gnt_i;
  // pick the sole requester, or on a tie the side that was not granted last
  always_comb begin
    win         = instr_req_i & data_req_i ? (last_q == ArbInstr ? ArbData : ArbInstr)
                : data_req_i ? ArbData : ArbInstr;
    mem_req_o   = live & (instr_req_i | data_req_i) & ~full;
    mem_we_o    = live & win == ArbData & data_we_i;
    mem_be_o    = ~live ? '0 : win == ArbData ? data_be_i : '1;
    mem_addr_o  = ~live ? '0 : win == ArbData ? data_addr_i : instr_addr_i;
    mem_wdata_o = ~live || win == ArbInstr ? '0 : data_wdata_i;
    instr_gnt_o = hs & win == ArbInstr;
    data_gnt_o  = hs & win == ArbData;
  end
  // route the response to whichever side issued the oldest outstanding request
  always_comb begin
    instr_rvalid_o = rsp & head == ArbInstr;
    data_rvalid_o  = rsp & head == ArbData;
    instr_rdata_o  = live ? mem_rdata_i : '0;
    data_rdata_o   = live ? mem_rdata_i : '0;
    instr_err_o    = live & mem_err_i;
    data_err_o     = live & mem_err_i;
    unexp_rsp_o    = live & unexp_q;
  end
  // round-robin history and sticky flag for responses nobody asked for
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q  <= ArbInstr;
      unexp_q <= 1'b0;
    end else begin
      if (hs) last_q <= win;
      if (mem_rvalid_i & empty) unexp_q <= 1'b1;
    end
  end
  ibex_arb_id_fifo #(.Depth(MaxOutstanding)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (hs),
    .pop   (rsp),
    .din   (win),
    .full  (full),
    .empty (empty),
    .head  (head)
  );
endmodule
